// File: rtl/csi_tx_pkg.sv
// Shared definitions for the CSI-2 TX payload framer: FSM states and footer CRC constants.
package csi_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CRC_LO,
    CRC_HI
  } tx_crc_state_e;

  localparam logic [15:0] CSI_CRC_SEED      = 16'hFFFF;
  localparam int          CSI_CRC_BYTES     = 2;
  // x^16+x^12+x^5+1 in reflected (LSB-first) form
  localparam logic [15:0] CSI_CRC_POLY_REFL = 16'h8408;

endpackage

// File: rtl/crc16_parallel.sv
// One-byte step of the CSI-2 footer CRC, LSB-first, shared with the RX checker.
module crc16_parallel
  import csi_tx_pkg::*;
(
  input  logic [15:0] crcIn,
  input  logic [7:0]  data,
  output logic [15:0] crcOut
);

  logic [15:0] c;

  always_comb begin
    c = crcIn;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CSI_CRC_POLY_REFL;
      else                c = c >> 1;
    end
    crcOut = c;
  end

endmodule

// File: rtl/csi_tx_payload_crc.sv
// CSI-2 long-packet TX framer: forwards payload bytes and appends the 16-bit footer CRC,
// low byte first, through a single registered output stage.
module csi_tx_payload_crc
  import csi_tx_pkg::*;
#(
  parameter int          WC_WIDTH = 16,
  parameter logic [15:0] CRC_SEED = CSI_CRC_SEED
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wc_valid_i,
  input  logic [WC_WIDTH-1:0] wc_i,
  output logic                wc_ready_o,
  input  logic                pld_valid_i,
  input  logic [7:0]          pld_data_i,
  output logic                pld_ready_o,
  output logic                out_valid_o,
  output logic [7:0]          out_data_o,
  output logic                out_last_o,
  input  logic                out_ready_i,
  output logic                busy_o
);

  tx_crc_state_e       state;
  logic [15:0]         crc;
  logic [15:0]         crc_next;
  logic [WC_WIDTH-1:0] cnt;
  logic                adv;
  logic                pld_acc;

  // The output register may take a new byte when it is empty or being drained
  assign adv         = !out_valid_o || out_ready_i;
  assign wc_ready_o  = (state == IDLE);
  assign pld_ready_o = (state == PAYLOAD) && adv;
  assign pld_acc     = pld_ready_o && pld_valid_i;
  assign busy_o      = (state != IDLE);

  crc16_parallel u_crc_step (
    .crcIn  (crc),
    .data   (pld_data_i),
    .crcOut (crc_next)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      crc         <= CRC_SEED;
      cnt         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= 8'h00;
      out_last_o  <= 1'b0;
    end else begin
      // Beat drained with nothing new to load; overridden below when a byte is loaded
      if (adv) out_valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (wc_valid_i) begin
            crc   <= CRC_SEED;
            cnt   <= wc_i;
            state <= (wc_i != '0) ? PAYLOAD : CRC_LO;
          end
        end
        PAYLOAD: begin
          if (pld_acc) begin
            out_data_o  <= pld_data_i;
            out_valid_o <= 1'b1;
            out_last_o  <= 1'b0;
            crc         <= crc_next;
            cnt         <= cnt - WC_WIDTH'(1);
            if (cnt == WC_WIDTH'(1)) state <= CRC_LO;
          end
        end
        CRC_LO: begin
          if (adv) begin
            out_data_o  <= crc[7:0];
            out_valid_o <= 1'b1;
            out_last_o  <= 1'b0;
            state       <= CRC_HI;
          end
        end
        CRC_HI: begin
          if (adv) begin
            out_data_o  <= crc[8*(CSI_CRC_BYTES-1) +: 8];
            out_valid_o <= 1'b1;
            out_last_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi_tx_payload_crc.sv
// Directed and randomized bench for csi_tx_payload_crc against a bit-reversed MSB-first CRC model.
module tb_csi_tx_payload_crc;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        wc_valid_i;
  logic [15:0] wc_i;
  logic        wc_ready_o;
  logic        pld_valid_i;
  logic [7:0]  pld_data_i;
  logic        pld_ready_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_last_o;
  logic        out_ready_i;
  logic        busy_o;

  always #5 clk = ~clk;

  csi_tx_payload_crc #(.WC_WIDTH(16), .CRC_SEED(16'hFFFF)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .wc_valid_i  (wc_valid_i),
    .wc_i        (wc_i),
    .wc_ready_o  (wc_ready_o),
    .pld_valid_i (pld_valid_i),
    .pld_data_i  (pld_data_i),
    .pld_ready_o (pld_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] obs_q[$];
  int         obs_cyc[$];
  logic [8:0] exp_q[$];
  logic [7:0] pkt[$];
  int         cyc = 0;
  int         stall_bad = 0;
  int         busy_cycles = 0;
  int         pld_rdy_cycles = 0;
  bit         rnd_mode = 1'b0;

  logic [7:0] vec1 [24] = '{8'hFF,8'h00,8'h00,8'h02,8'hB9,8'hDC,8'hF3,8'h72,8'hBB,8'hD4,8'hB8,8'h5A,
                            8'hC8,8'h75,8'hC2,8'h7C,8'h81,8'hF8,8'h05,8'hDF,8'hFF,8'h00,8'h00,8'h01};
  logic [7:0] vec2 [24] = '{8'hFF,8'h00,8'h00,8'h00,8'h1E,8'hF0,8'h1E,8'hC7,8'h4F,8'h82,8'h78,8'hC5,
                            8'h82,8'hE0,8'h8C,8'h70,8'hD2,8'h3C,8'h78,8'hE9,8'hFF,8'h00,8'h00,8'h01};

  // Output monitor: records accepted beats and checks that stalled beats hold steady
  initial begin
    logic       prev_stall;
    logic [8:0] prev_beat;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !(out_valid_o && {out_last_o, out_data_o} == prev_beat)) stall_bad++;
        if (busy_o) busy_cycles++;
        if (pld_ready_o) pld_rdy_cycles++;
        if (out_valid_o && out_ready_i) begin
          obs_q.push_back({out_last_o, out_data_o});
          obs_cyc.push_back(cyc);
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_beat  = {out_last_o, out_data_o};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] w);
    for (int i = 0; i < 16; i++) rev16[i] = w[15-i];
  endfunction

  // Reflected CRC computed as the plain MSB-first CCITT CRC over bit-reversed bytes, result reversed
  function automatic logic [15:0] crc_ref();
    logic [15:0] r;
    r = 16'hFFFF;
    foreach (pkt[k]) begin
      r = r ^ {rev8(pkt[k]), 8'h00};
      for (int j = 0; j < 8; j++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return rev16(r);
  endfunction

  task automatic push_exp(input logic [15:0] trailer);
    foreach (pkt[k]) exp_q.push_back({1'b0, pkt[k]});
    exp_q.push_back({1'b0, trailer[7:0]});
    exp_q.push_back({1'b1, trailer[15:8]});
  endtask

  task automatic load_vec(input int which);
    pkt.delete();
    for (int k = 0; k < 24; k++) pkt.push_back(which == 1 ? vec1[k] : vec2[k]);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, 32'(out_valid_o), 0);
    chk({tag, "_out_data"},  32'(out_data_o),  0);
    chk({tag, "_out_last"},  32'(out_last_o),  0);
    chk({tag, "_busy"},      32'(busy_o),      0);
    chk({tag, "_wc_ready"},  32'(wc_ready_o),  1);
    chk({tag, "_pld_ready"}, 32'(pld_ready_o), 0);
  endtask

  task automatic send(input int abort_at);
    int g;
    bit acc;
    wc_valid_i = 1'b1;
    wc_i       = 16'(pkt.size());
    acc = 1'b0;
    g   = 0;
    while (!acc && g < 1000) begin
      if (rnd_mode) out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = wc_ready_o;
      @(posedge clk); #1;
      g++;
    end
    wc_valid_i = 1'b0;
    chk("wc_accept", 32'(acc), 1);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == abort_at) begin
        pld_valid_i = 1'b0;
        reset_i     = 1'b1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        reset_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        return;
      end
      pld_data_i = pkt[i];
      acc = 1'b0;
      g   = 0;
      while (!acc && g < 1000) begin
        pld_valid_i = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rnd_mode) out_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = pld_valid_i && pld_ready_o;
        @(posedge clk); #1;
        g++;
      end
      pld_valid_i = 1'b0;
      chk($sformatf("pld_accept_%0d", i), 32'(acc), 1);
    end
  endtask

  task automatic drain(input int n);
    int g;
    g = 0;
    while (obs_q.size() < n && g < 2000) begin
      if (rnd_mode) out_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      g++;
    end
    out_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  function automatic int count_last();
    int c;
    c = 0;
    foreach (obs_q[k]) if (obs_q[k][8]) c++;
    return c;
  endfunction

  initial begin
    int n;
    reset_i     = 1'b1;
    wc_valid_i  = 1'b0;
    wc_i        = '0;
    pld_valid_i = 1'b0;
    pld_data_i  = '0;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(posedge clk); #1;

    // Known vector 1 at full rate: trailer F0 00, 26 contiguous beats
    clear_obs();
    load_vec(1);
    push_exp(16'h00F0);
    send(-1);
    drain(26);
    check_seq("vec1");
    if (obs_cyc.size() == 26) chk("vec1_contig", 32'(obs_cyc[25] - obs_cyc[0]), 25);
    else chk("vec1_contig_beats", 32'(obs_cyc.size()), 26);

    // Known vector 2: trailer 69 E5
    clear_obs();
    load_vec(2);
    push_exp(16'hE569);
    send(-1);
    drain(26);
    check_seq("vec2");

    // Zero word count
    clear_obs();
    pkt.delete();
    push_exp(16'hFFFF);
    busy_cycles    = 0;
    pld_rdy_cycles = 0;
    send(-1);
    drain(2);
    check_seq("wc0");
    chk("wc0_busy_cycles", 32'(busy_cycles), 2);
    chk("wc0_pld_ready", 32'(pld_rdy_cycles), 0);

    // Vector 1 with random backpressure and payload gaps
    clear_obs();
    rnd_mode  = 1'b1;
    stall_bad = 0;
    load_vec(1);
    push_exp(16'h00F0);
    send(-1);
    drain(26);
    rnd_mode = 1'b0;
    check_seq("vec1_rnd");
    chk("vec1_rnd_stall_hold", 32'(stall_bad), 0);

    // Reset during byte 10 abandons the packet; the next one starts clean
    clear_obs();
    load_vec(1);
    send(10);
    chk("abort_no_last", 32'(count_last()), 0);
    chk("abort_len_le10", 32'(obs_q.size() <= 10), 1);
    for (int i = 0; i < obs_q.size() && i < 10; i++)
      chk($sformatf("abort_prefix%0d", i), 32'(obs_q[i]), 32'({1'b0, vec1[i]}));
    clear_obs();
    load_vec(2);
    push_exp(16'hE569);
    send(-1);
    drain(26);
    check_seq("after_abort");

    // Back-to-back: vector 1 then a single 00 byte
    clear_obs();
    load_vec(1);
    push_exp(16'h00F0);
    send(-1);
    pkt.delete();
    pkt.push_back(8'h00);
    push_exp(crc_ref());
    send(-1);
    drain(29);
    check_seq("b2b");
    chk("b2b_last_count", 32'(count_last()), 2);

    // Random packets with random flow control
    for (int p = 0; p < 4; p++) begin
      clear_obs();
      rnd_mode  = 1'b1;
      stall_bad = 0;
      pkt.delete();
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) pkt.push_back(8'($urandom_range(0, 255)));
      push_exp(crc_ref());
      send(-1);
      drain(n + 2);
      rnd_mode = 1'b0;
      check_seq($sformatf("rand%0d", p));
      chk($sformatf("rand%0d_stall_hold", p), 32'(stall_bad), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
